// File: rtl/bz_router_pkg.sv
// Shared router flit definitions, used by the packetizer and the downstream deserializer.
package bz_router_pkg;

   localparam int FLIT_W    = 11;
   localparam int TAIL_BIT  = 10;
   localparam int NPCroute  = 10;
   localparam int NPCdata   = 30;

   // Split of the 30 routed word bits into three 10-bit payloads
   localparam int W_HI_MSB  = 29;
   localparam int W_HI_LSB  = 20;
   localparam int W_MID_MSB = 19;
   localparam int W_MID_LSB = 10;
   localparam int W_LO_MSB  = 9;
   localparam int W_LO_LSB  = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      F0   = 3'd2,
      F1   = 3'd3,
      F2   = 3'd4
   } bz_state_e;

endpackage

// File: rtl/bz_packetizer.sv
// Turns 32-bit core words into 11-bit router flits: one header per packet, three
// data flits per word, merging back-to-back same-route words up to MAX_WORDS.
//
// state | meaning
// IDLE  | waiting for a word; a follows v
// HDR   | emitting header flit (route)
// F0    | emitting word bits 29:20
// F1    | emitting word bits 19:10
// F2    | emitting word bits 9:0, tail unless next word merges
module bz_packetizer
   import bz_router_pkg::*;
#(
   parameter int MAX_WORDS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                PC_in_channel_v,
   output logic                PC_in_channel_a,
   input  logic [31:0]         PC_in_channel_d,
   input  logic [NPCroute-1:0] route,
   input  logic                isfull,
   output logic [FLIT_W-1:0]   data_out,
   output logic                wrreq,
   output logic                code_err,
   output logic [15:0]         pkt_count
);

   localparam logic [3:0] MAX_W = 4'(MAX_WORDS);

   bz_state_e             state_q, state_d;
   logic [NPCdata-1:0]    word_q;
   logic [NPCroute-1:0]   cur_route_q;
   logic [3:0]            cnt_q;
   logic                  code_err_q;
   logic [15:0]           pkt_count_q;

   logic                  wr;
   logic                  cont;
   logic                  accept;

   assign wr     = (state_q != IDLE) && !isfull;
   assign cont   = PC_in_channel_v && (route == cur_route_q) && (cnt_q < MAX_W);
   assign accept = PC_in_channel_v && PC_in_channel_a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = HDR;
         HDR:     if (wr)     state_d = F0;
         F0:      if (wr)     state_d = F1;
         F1:      if (wr)     state_d = F2;
         F2:      if (wr)     state_d = cont ? F0 : IDLE;
         default:             state_d = IDLE;
      endcase
   end

   always_comb begin
      PC_in_channel_a = 1'b0;
      data_out        = '0;
      wrreq           = wr;
      case (state_q)
         IDLE: PC_in_channel_a = PC_in_channel_v && !isfull;
         HDR:  data_out = {1'b0, cur_route_q};
         F0:   data_out = {1'b0, word_q[W_HI_MSB:W_HI_LSB]};
         F1:   data_out = {1'b0, word_q[W_MID_MSB:W_MID_LSB]};
         F2: begin
            // Tail follows live v/route while stalled; only the written value matters
            data_out        = {!cont, word_q[W_LO_MSB:W_LO_LSB]};
            PC_in_channel_a = cont && !isfull;
         end
         default: data_out = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q      <= '0;
         cur_route_q <= '0;
         cnt_q       <= '0;
         code_err_q  <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         if (accept) begin
            word_q      <= PC_in_channel_d[NPCdata-1:0];
            cur_route_q <= route;
            cnt_q       <= (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
            if (PC_in_channel_d[31:30] != 2'b00) begin
               code_err_q <= 1'b1;
            end
         end
         if ((state_q == F2) && wr && !cont) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
      end
   end

   assign code_err  = code_err_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_bz_packetizer.sv
// Directed bench for bz_packetizer: a packet-level flit model plus literal flit checks.
module tb_bz_packetizer;

   localparam int MAXW = 4;

   logic        clk;
   logic        reset;
   logic        pc_v;
   logic        pc_a;
   logic [31:0] pc_d;
   logic [9:0]  route_s;
   logic        isfull_s;
   logic [10:0] data_out;
   logic        wrreq;
   logic        code_err;
   logic [15:0] pkt_count;

   bz_packetizer #(.MAX_WORDS(MAXW)) dut (
      .clk             (clk),
      .reset           (reset),
      .PC_in_channel_v (pc_v),
      .PC_in_channel_a (pc_a),
      .PC_in_channel_d (pc_d),
      .route           (route_s),
      .isfull          (isfull_s),
      .data_out        (data_out),
      .wrreq           (wrreq),
      .code_err        (code_err),
      .pkt_count       (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [10:0] exp_q[$];
   logic [10:0] log_d[$];
   int          log_t[$];

   bit          m_open;
   logic [9:0]  m_route;
   int          m_cnt;
   int          m_pkts;
   bit          m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packet-level model: a word either extends the open packet or opens a new one.
   task automatic model_word(input bit gap, input logic [9:0] r, input logic [31:0] d);
      logic [10:0] last;
      logic [29:0] w;
      w = d[29:0];
      if (m_open && !gap && r == m_route && m_cnt < MAXW) begin
         last = exp_q.pop_back();
         last[10] = 1'b0;
         exp_q.push_back(last);
         m_cnt++;
      end else begin
         m_pkts++;
         m_cnt   = 1;
         m_open  = 1'b1;
         m_route = r;
         exp_q.push_back({1'b0, r});
      end
      exp_q.push_back({1'b0, 10'((w / 30'h100000) % 1024)});
      exp_q.push_back({1'b0, 10'((w / 30'h400) % 1024)});
      exp_q.push_back({1'b1, 10'(w % 1024)});
      if (d[31:30] != 2'b00) m_err = 1'b1;
   endtask

   task automatic monitor();
      logic [10:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset && wrreq) begin
            log_d.push_back(data_out);
            log_t.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL flit_unexpected: got %0h expected none", data_out);
            end else begin
               e = exp_q.pop_front();
               chk("flit", {21'b0, data_out}, {21'b0, e});
            end
         end
      end
   endtask

   // Presents a word and holds it until accepted; returns 1ns after the accepting edge.
   task automatic put_word(input bit gap, input logic [9:0] r, input logic [31:0] d);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      model_word(gap, r, d);
      route_s = r;
      pc_d    = d;
      pc_v    = 1'b1;
      while (!got && n < 200) begin
         @(negedge clk);
         got = pc_a;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no a expected a within 200 cycles");
      end
   endtask

   task automatic idle(input int n);
      pc_v = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_chk();
      chk("drain", exp_q.size(), 0);
      chk("pkt_count", {16'b0, pkt_count}, m_pkts);
      chk("code_err", {31'b0, code_err}, {31'b0, m_err});
   endtask

   initial begin
      int lb;
      int tails;
      logic [10:0] exp_lit[7];
      reset    = 1'b1;
      pc_v     = 1'b0;
      pc_d     = '0;
      route_s  = '0;
      isfull_s = 1'b0;
      m_open = 0; m_route = '0; m_cnt = 0; m_pkts = 0; m_err = 0;
      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wrreq", {31'b0, wrreq}, 0);
      chk("rst_data_out", {21'b0, data_out}, 0);
      chk("rst_a", {31'b0, pc_a}, 0);
      chk("rst_code_err", {31'b0, code_err}, 0);
      chk("rst_pkt_count", {16'b0, pkt_count}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // Single word
      lb = log_d.size();
      put_word(1'b1, 10'h155, 32'h0ABCDE12);
      idle(8);
      exp_lit[0] = 11'h155; exp_lit[1] = 11'h0AB; exp_lit[2] = 11'h337; exp_lit[3] = 11'h612;
      chk("single_len", log_d.size() - lb, 4);
      for (int i = 0; i < 4; i++) chk("single_lit", {21'b0, log_d[lb+i]}, {21'b0, exp_lit[i]});
      chk("single_pkts", {16'b0, pkt_count}, 1);
      drain_chk();

      // Merge of two words, no gap
      lb = log_d.size();
      put_word(1'b1, 10'h155, 32'h0ABCDE12);
      put_word(1'b0, 10'h155, 32'h00000001);
      idle(10);
      exp_lit[0] = 11'h155; exp_lit[1] = 11'h0AB; exp_lit[2] = 11'h337; exp_lit[3] = 11'h212;
      exp_lit[4] = 11'h000; exp_lit[5] = 11'h000; exp_lit[6] = 11'h401;
      chk("merge_len", log_d.size() - lb, 7);
      for (int i = 0; i < 7; i++) chk("merge_lit", {21'b0, log_d[lb+i]}, {21'b0, exp_lit[i]});
      chk("merge_nogap", log_t[lb+6] - log_t[lb], 6);
      chk("merge_pkts", {16'b0, pkt_count}, 2);
      drain_chk();

      // Word limit: six words, MAX_WORDS=4
      lb = log_d.size();
      for (int i = 0; i < 6; i++) put_word(i == 0, 10'h001, 32'(i + 1));
      idle(12);
      chk("limit_len", log_d.size() - lb, 20);
      tails = 0;
      for (int i = 0; i < 20; i++) if (log_d[lb+i][10]) tails++;
      chk("limit_tails", tails, 2);
      chk("limit_tail13", {31'b0, log_d[lb+12][10]}, 1);
      chk("limit_hdr2", {21'b0, log_d[lb+13]}, 32'h001);
      chk("limit_tail20", {31'b0, log_d[lb+19][10]}, 1);
      chk("limit_pkts", {16'b0, pkt_count}, 4);
      drain_chk();

      // Backpressure: five stalled cycles starting in F1
      lb = log_d.size();
      put_word(1'b1, 10'h0F0, 32'h0ABCDE12);
      pc_v = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      isfull_s = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_wrreq", {31'b0, wrreq}, 0);
         chk("stall_data", {21'b0, data_out}, 32'h337);
         @(posedge clk); #1;
      end
      isfull_s = 1'b0;
      idle(8);
      exp_lit[0] = 11'h0F0; exp_lit[1] = 11'h0AB; exp_lit[2] = 11'h337; exp_lit[3] = 11'h612;
      chk("bp_len", log_d.size() - lb, 4);
      for (int i = 0; i < 4; i++) chk("bp_lit", {21'b0, log_d[lb+i]}, {21'b0, exp_lit[i]});
      drain_chk();

      // Route change with a coded word
      lb = log_d.size();
      chk("cerr_before", {31'b0, code_err}, 0);
      put_word(1'b1, 10'h002, 32'hC0000003);
      put_word(1'b0, 10'h003, 32'h00000004);
      idle(12);
      exp_lit[0] = 11'h002; exp_lit[1] = 11'h000; exp_lit[2] = 11'h000; exp_lit[3] = 11'h403;
      exp_lit[4] = 11'h003;
      chk("rc_len", log_d.size() - lb, 8);
      for (int i = 0; i < 5; i++) chk("rc_lit", {21'b0, log_d[lb+i]}, {21'b0, exp_lit[i]});
      chk("rc_code_err", {31'b0, code_err}, 1);
      chk("rc_pkts", {16'b0, pkt_count}, 7);
      drain_chk();

      // Reset while in F0
      put_word(1'b1, 10'h0AA, 32'h12345678);
      pc_v = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("f0_data", {21'b0, data_out}, 32'h123);
      #2 reset = 1'b1;
      #1;
      chk("arst_wrreq", {31'b0, wrreq}, 0);
      chk("arst_data_out", {21'b0, data_out}, 0);
      chk("arst_a", {31'b0, pc_a}, 0);
      chk("arst_code_err", {31'b0, code_err}, 0);
      chk("arst_pkt_count", {16'b0, pkt_count}, 0);
      exp_q.delete();
      m_open = 0; m_cnt = 0; m_pkts = 0; m_err = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);
      lb = log_d.size();
      put_word(1'b1, 10'h0BB, 32'h00000005);
      idle(8);
      chk("post_rst_len", log_d.size() - lb, 4);
      chk("post_rst_hdr", {21'b0, log_d[lb]}, 32'h0BB);
      chk("post_rst_last", {21'b0, log_d[lb+3]}, 32'h405);
      chk("post_rst_pkts", {16'b0, pkt_count}, 1);
      drain_chk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bz_packetizer.md
Name: bz_packetizer

Overview:
- Upstream stage of the router-to-core deserializer. Consumes 32-bit core output words on a Channel and writes 11-bit router flits into a FIFO.
- Each packet is one header flit carrying the route, followed by three 10-bit data flits per word.
- Back-to-back words with the same route are merged into one packet, up to MAX_WORDS words. The tail bit is set only on the final flit of the packet.

Parameters:
- NPCroute, 10, route width; equals the flit payload width.
- NPCdata, 30, routed word bits taken from d[29:0]; d[31:30] are not routed.
- MAX_WORDS, 4, maximum words per packet, range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- PC_in_channel  Channel  v/a/d[31:0]  core output words. Sender holds v and d until a is seen.
- route  input  10  destination route; must be stable while PC_in_channel.v=1.
- isfull  input  1  full flag of the downstream flit FIFO.
- data_out  output  11  flit: [10]=tail, [9:0]=payload.
- wrreq  output  1  FIFO write strobe; a flit is written on every cycle wrreq=1.
- code_err  output  1  sticky flag: an accepted word had d[31:30]!=0.
- pkt_count  output  16  count of completed packets; wraps at 2^16.

Behaviour:
- Reset values (asynchronous): state=IDLE, data_out=0, wrreq=0, PC_in_channel.a=0, code_err=0, pkt_count=0, word counter=0.
- Word acceptance: a word is accepted in a cycle where v=1 and a=1. a is combinational and is never high for two consecutive cycles on the same word.
- Capture: on acceptance, latch d[29:0] and route (into cur_route). If d[31:30]!=0, set code_err; that word is still sent with those bits dropped.
- wrreq = (state!=IDLE) && !isfull.
- When isfull=1: state, data_out and all registers hold; a=0.

State machine:
- IDLE: a=v. On acceptance -> HDR, word counter=1.
- HDR: data_out={1'b0, cur_route}. On write -> F0.
- F0: data_out={1'b0, w[29:20]}. On write -> F1.
- F1: data_out={1'b0, w[19:10]}. On write -> F2.
- F2: data_out={tail, w[9:0]}, where
  - cont = v && (route==cur_route) && (word counter < MAX_WORDS)
  - tail = !cont.
  - On write with cont=1: a=1, capture the next word, increment word counter, -> F0 (no new header).
  - On write with cont=0: pkt_count+1, -> IDLE.
- cont is evaluated only in a cycle where the F2 write actually occurs. When isfull stalls F2, tail tracks the current v/route each cycle, but no acceptance happens.

Timing:
- Latency: word accepted in cycle t, header written at t+1 at the earliest, last flit at t+4.
- Throughput with no backpressure: 4 flits for the first word of a packet, 3 flits for each merged word.
- No IDLE bubble occurs between merged words. One IDLE cycle occurs between packets.

Boundary conditions:
- MAX_WORDS=1: every word is sent as its own packet; tail is always set on F2.
- Route change while a packet is open: the current packet closes with tail=1, and the new word starts a new header after IDLE.
- v drops during F2: the packet closes.
- Reset mid-packet: the partial packet is abandoned with no tail written. The downstream stage must be reset in the same cycle; this is a system-level requirement.
- pkt_count wraps 0xFFFF -> 0x0000.
- code_err clears only on reset.

Decomposition:
- Shared package bz_router_pkg holds: FLIT_W=11, TAIL_BIT=10, NPCroute, the PC word split constants (hi=29:20, mid=19:10, lo=9:0), and the state enum {IDLE, HDR, F0, F1, F2}. The downstream deserializer reuses these.
- No sub-module; the flit mux is a single case statement inside this block.

Test Plan:
- Single word: d=0x0ABCDE12, route=0x155, isfull=0. Expected flits 0x155, 0x0AB, 0x337, 0x612, one per cycle; pkt_count=1; code_err=0.
- Merge: two words 0x0ABCDE12 and 0x00000001 on route 0x155 presented back-to-back. Expected flits 0x155, 0x0AB, 0x337, 0x212, 0x000, 0x000, 0x401 with no gap; pkt_count=1.
- Limit: 6 words on route 0x001 with MAX_WORDS=4. Expected two headers: tail on the 13th flit, a new header, tail on the 20th flit; pkt_count=2.
- Backpressure: isfull held high for 5 cycles starting in F1. Expected wrreq=0 and data_out stable at the F1 flit; resumes with no flit lost or duplicated.
- Route change and code error: word 0xC0000003 on route 0x002, then a word on route 0x003. Expected code_err=1 with flits 0x002, 0x000, 0x000, 0x403, then a new header 0x003; pkt_count=2.
- Reset asserted in F0: all outputs return to their reset values asynchronously. After release, a new word produces a fresh header.
